// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Double-flop synchronises the asynchronous rx
//            line, samples each bit once at its mid-point using a bit timer,
//            and hands received bytes to the consumer through a one-entry
//            valid/ready output register. Framing and overrun errors are
//            reported as one-cycle pulses.
// Ports    : clk           - system clock, rising edge
//            reset         - asynchronous, active-high reset
//            rx            - serial line, idle high, asynchronous to clk
//            rx_data[7:0]  - received byte, stable while rx_valid=1
//            rx_valid      - rx_data holds an unconsumed byte
//            rx_ready      - consumer accepts byte when rx_valid & rx_ready
//            frame_error   - one-cycle pulse, stop bit sampled low
//            overrun_error - one-cycle pulse, byte dropped (register full)
//            busy          - receiver is in any state other than IDLE
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,  // even, >= 4
  parameter int CNT_W        = 16   // must hold CLKS_PER_BIT-1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       busy
);

  // Timer terminal counts. The START state counts to the half-bit point so
  // every later sample lands one full bit period after the previous one.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] timer_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_error_q;
  logic             overrun_error_q;

  logic             rx_s;
  logic             half_pt_d;
  logic             bit_pt_d;
  logic             can_load_d;

  assign rx_s       = sync2_q;
  assign half_pt_d  = (timer_q == HALF_M1);
  assign bit_pt_d   = (timer_q == FULL_M1);
  // The output register is free if empty or being drained on this same edge.
  assign can_load_d = ~rx_valid_q | rx_ready;

  // Synchroniser flops reset to the idle line level so that reset release
  // never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      frame_error_q   <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      frame_error_q   <= 1'b0;
      overrun_error_q <= 1'b0;

      // Consumer handshake; a byte loading on this same edge overrides it.
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // Timer held at zero so each frame restarts timing from its own t0.
          timer_q <= '0;
          if (!rx_s) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (half_pt_d) begin
            timer_q <= '0;
            if (!rx_s) begin
              state_q   <= S_DATA;
              bit_idx_q <= 3'd0;
            end else begin
              // Line went high again before mid-start: treat as a glitch.
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q + CNT_ONE;
          end
        end

        S_DATA: begin
          if (bit_pt_d) begin
            timer_q            <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            timer_q <= timer_q + CNT_ONE;
          end
        end

        S_STOP: begin
          if (bit_pt_d) begin
            timer_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
              if (can_load_d) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_error_q <= 1'b1;
              end
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= S_WAIT_HIGH;
            end
          end else begin
            timer_q <= timer_q + CNT_ONE;
          end
        end

        S_WAIT_HIGH: begin
          // Hold off until the line is released so a break yields one error.
          if (rx_s) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign frame_error   = frame_error_q;
  assign overrun_error = overrun_error_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Expected bytes are queued when
//            a frame is driven and compared when the consumer takes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  logic [7:0] sb[$];

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_error  (frame_error),
    .overrun_error(overrun_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard / pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_error)   fe_cnt++;
      if (overrun_error) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_byte actual=0x%0h required=none", rx_data);
        end else begin
          chk("sb_byte", {24'h0, rx_data}, {24'h0, sb.pop_front()});
        end
      end
    end
  end

  // All drivers below are entered and left just after a rising edge.
  task automatic hold_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    hold_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_deliver;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];
  int   fe0;
  int   ov0;

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hC3, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 0};

    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_frame_error", {31'h0, frame_error}, 32'h0);
    chk("reset_overrun", {31'h0, overrun_error}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);

    // Table-driven frames, consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      if (vecs[i].exp_deliver) sb.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle(4);
      chk($sformatf("vec%0d_frame_error", i), fe_cnt - fe0, vecs[i].exp_fe);
      chk($sformatf("vec%0d_overrun", i), ov_cnt - ov0, 0);
      chk($sformatf("vec%0d_sb_drained", i), sb.size(), 0);
      chk($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
    end

    // Test 1: exact delivery latency and busy start for 0xA5.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_busy_at_t0", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("t1_busy_at_t0p1", {31'h0, busy}, 32'h1);
        repeat (151) @(posedge clk);
        @(negedge clk);
        chk("t1_valid_before", {31'h0, rx_valid}, 32'h0);
        @(negedge clk);
        chk("t1_valid_at_155", {31'h0, rx_valid}, 32'h1);
        chk("t1_data", {24'h0, rx_data}, 32'hA5);
        @(negedge clk);
        chk("t1_valid_one_cycle", {31'h0, rx_valid}, 32'h0);
      end
    join
    idle(4);
    chk("t1_frame_error", fe_cnt - fe0, 0);
    chk("t1_overrun", ov_cnt - ov0, 0);

    // Test 2: back-to-back 0x00, 0xFF with consumer stalled.
    rx_ready = 1'b0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    sb.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    chk("t2_valid_held", {31'h0, rx_valid}, 32'h1);
    chk("t2_data_held", {24'h0, rx_data}, 32'h00);
    chk("t2_overrun_once", ov_cnt - ov0, 1);
    chk("t2_frame_error", fe_cnt - fe0, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    chk("t2_valid_cleared", {31'h0, rx_valid}, 32'h0);
    chk("t2_sb_drained", sb.size(), 0);
    @(posedge clk);
    #1;

    // Test 3: bad stop then 40-bit break, then recovery with 0x12.
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    #1;
    chk("t3_busy_in_break", {31'h0, busy}, 32'h1);
    chk("t3_frame_error_once", fe_cnt - fe0, 1);
    chk("t3_no_valid", {31'h0, rx_valid}, 32'h0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_busy_before_release", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("t3_busy_after_release", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    idle(4);
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle(4);
    chk("t3_sb_drained", sb.size(), 0);
    chk("t3_frame_error_total", fe_cnt - fe0, 1);

    // Test 4: 5-clk glitch aborts in START; 0x81 follows.
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_busy_during_glitch", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    idle(20);
    chk("t4_busy_after_abort", {31'h0, busy}, 32'h0);
    chk("t4_no_valid", {31'h0, rx_valid}, 32'h0);
    chk("t4_no_frame_error", fe_cnt - fe0, 0);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(4);
    chk("t4_sb_drained", sb.size(), 0);

    // Test 6: ready asserted exactly in the delivery cycle of 0x22.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(4);
    chk("t6_held_data", {24'h0, rx_data}, 32'h11);
    sb.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(negedge clk);
        chk("t6_old_still_visible", {24'h0, rx_data}, 32'h11);
        @(negedge clk);
        chk("t6_valid_stays", {31'h0, rx_valid}, 32'h1);
        chk("t6_new_data", {24'h0, rx_data}, 32'h22);
      end
    join
    idle(4);
    chk("t6_no_overrun", ov_cnt - ov0, 0);
    chk("t6_sb_drained", sb.size(), 0);

    // Test 5: reset in the middle of data bit 4 of 0x55.
    rx_ready = 1'b0;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(4);
    chk("t5_pre_valid", {31'h0, rx_valid}, 32'h1);
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    chk("t5_busy_mid_frame", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_async_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("t5_async_rx_data", {24'h0, rx_data}, 32'h0);
    chk("t5_async_busy", {31'h0, busy}, 32'h0);
    chk("t5_async_errors", {30'h0, frame_error, overrun_error}, 32'h0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3 * CPB);
    chk("t5_no_byte_after", {31'h0, rx_valid}, 32'h0);
    chk("t5_idle_busy", {31'h0, busy}, 32'h0);
    rx_ready = 1'b1;
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(4);
    chk("t5_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
